pc_register_unit: RTL

- Holds the architectural program counter and drives the instruction-memory fetch address.
- Consumes the incremented value from the PC adder (PC+1, word-addressed) and feeds pc_o back to the adder input.
- Selects the next PC from sequential, branch and jump sources.
- Holds on pipeline stall or instruction-memory backpressure, and buffers one redirect that arrives while it cannot advance.

---
 rtl/pc_register_unit.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/pc_register_unit.sv
// Program counter register with BOOT/RUN/HOLD/HALT sequencing, redirect buffering and fetch handshake.
// Optional next-PC bound check enabled by defining PC_BOUND_CHECK_EN.
module pc_register_unit #(
    parameter int unsigned     XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int unsigned     IMEM_DEPTH = 256
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] pc_plus1_i,
    input  logic            branch_taken_i,
    input  logic [XLEN-1:0] branch_target_i,
    input  logic            jump_i,
    input  logic [XLEN-1:0] jump_target_i,
    input  logic            stall_i,
    input  logic            halt_i,
    input  logic            imem_ready_i,
    output logic [XLEN-1:0] pc_o,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    output logic            fetch_valid_o,
    output logic            pc_fault_o
);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HOLD,
        HALT
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;
    logic            pend_q, pend_d;
    logic            fv_q, fv_d;
    logic            active, accept;
    logic            new_redirect, redirect_req;
    logic [XLEN-1:0] redirect_tgt, next_pc;
`ifdef PC_BOUND_CHECK_EN
    logic            fault_q, fault_d;
    logic            out_of_range;
`endif

    assign active       = (state_q == RUN) || (state_q == HOLD);
    assign accept       = active && imem_ready_i && !stall_i;
    assign new_redirect = jump_i || branch_taken_i;
    assign redirect_req = new_redirect || pend_q;

    // Jump beats branch; a fresh redirect supersedes the buffered one.
    assign redirect_tgt = jump_i         ? jump_target_i   :
                          branch_taken_i ? branch_target_i :
                                           pend_tgt_q;
    assign next_pc      = redirect_req ? redirect_tgt : pc_plus1_i;

`ifdef PC_BOUND_CHECK_EN
    assign out_of_range = {1'b0, next_pc} >= (XLEN+1)'(IMEM_DEPTH);
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_d     = pend_q;
        pend_tgt_d = pend_tgt_q;
        fv_d       = 1'b0;
`ifdef PC_BOUND_CHECK_EN
        fault_d    = fault_q;
`endif
        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN, HOLD: begin
                if (halt_i) begin
                    state_d = HALT;
                    pend_d  = 1'b0;
                    fv_d    = accept;
                end else if (accept) begin
`ifdef PC_BOUND_CHECK_EN
                    if (out_of_range) begin
                        state_d = HALT;
                        pend_d  = 1'b0;
                        fault_d = 1'b1;
                    end else begin
                        state_d = RUN;
                        pc_d    = next_pc;
                        pend_d  = 1'b0;
                        fv_d    = !redirect_req;
                    end
`else
                    state_d = RUN;
                    pc_d    = next_pc;
                    pend_d  = 1'b0;
                    fv_d    = !redirect_req;
`endif
                end else begin
                    state_d = HOLD;
                    if (new_redirect) begin
                        pend_d     = 1'b1;
                        pend_tgt_d = redirect_tgt;
                    end
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            pend_q     <= 1'b0;
            pend_tgt_q <= '0;
            fv_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            pend_tgt_q <= pend_tgt_d;
            fv_q       <= fv_d;
        end
    end

`ifdef PC_BOUND_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    assign pc_fault_o = fault_q;
`else
    assign pc_fault_o = 1'b0;
`endif

    assign pc_o          = pc_q;
    assign imem_addr_o   = pc_q;
    assign imem_req_o    = active;
    assign fetch_valid_o = fv_q;

endmodule
